// File: rtl/prog_run_ctrl_pkg.sv
// Shared types and constants for the program load-and-run controller.
package prog_run_pkg;

    // Controller phases: idle, streaming the image, holding the core in
    // reset, letting it run, and holding the verdict.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } run_state_e;

    // Address the test program stores its verdict to.
    localparam logic [31:0] TOHOST_ADDR_DEF = 32'h0000_1000;

    // Verdict value meaning "all tests passed".
    localparam logic [31:0] PASS_CODE = 32'd1;

    // A store terminates the run only when it targets tohost with a
    // non-zero value; a zero store is the program clearing the mailbox.
    function automatic logic is_tohost_hit(
        input logic        we,
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [31:0] tohost
    );
        return we && (addr == tohost) && (wdata != 32'd0);
    endfunction

endpackage

// File: rtl/prog_run_ctrl_if.sv
// Load stream into the controller and the instruction-memory write port
// that comes out of it.
interface prog_run_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;

    // Loader side: offers words, observes the memory writes.
    modport master (
        output ld_valid, ld_data, ld_last,
        input  ld_ready, imem_we, imem_addr, imem_wdata
    );

    // Controller side: accepts words, issues the memory writes.
    modport slave (
        input  ld_valid, ld_data, ld_last,
        output ld_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/prog_run_ctrl_run_watchdog.sv
// RUN-cycle counter with a programmable expiry compare.
// The count saturates at all-ones and does not advance on the cycle the
// run terminates, so it reports the number of RUN cycles before the end.
module run_watchdog #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             expired
);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] count_r;
    logic             expired_s;
    logic             bump_s;

    // Expiry is reached on the last budgeted cycle; a zero limit disables it.
    always_comb begin
        expired_s = enable && (limit != CNT_ZERO) && (count_r == (limit - CNT_ONE));
        bump_s    = enable && !expired_s && (count_r != CNT_MAX);
    end

    // Cycle counter: cleared on a new run, advanced on each live RUN cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= CNT_ZERO;
        end else if (clear) begin
            count_r <= CNT_ZERO;
        end else if (bump_s) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign expired = expired_s;

endmodule

// File: rtl/prog_run_ctrl.sv
// Load-and-run controller: streams a program image into instruction memory,
// holds the core in reset for a fixed window, releases it, and watches its
// stores to the tohost mailbox (or a cycle budget) to produce a verdict.
module prog_run_ctrl
    import prog_run_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter int          DATA_W      = 32,
    parameter int          CNT_W       = 32,
    parameter int          RESET_HOLD  = 4,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    prog_run_ctrl_if.slave   ld,
    output logic             core_reset,
    input  logic             mon_we,
    input  logic [31:0]      mon_addr,
    input  logic [31:0]      mon_wdata,
    input  logic [CNT_W-1:0] timeout_limit,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [30:0]      fail_code,
    output logic             timed_out,
    output logic             load_ovf,
    output logic [CNT_W-1:0] cycle_count
);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
    localparam int                HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);

    run_state_e        state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [HOLD_W-1:0] hold_cnt_r;
    logic              ld_ready_r;
    logic              imem_we_r;
    logic [ADDR_W-1:0] imem_addr_r;
    logic [DATA_W-1:0] imem_wdata_r;
    logic              core_reset_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [30:0]       fail_code_r;
    logic              timed_out_r;
    logic              load_ovf_r;

    logic              start_ok_s;
    logic              handshake_s;
    logic              hit_s;
    logic              wd_enable_s;
    logic              wd_expired_s;

    // Decode of the events that steer the FSM this cycle.
    always_comb begin
        start_ok_s  = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        handshake_s = ld.ld_valid && ld_ready_r;
        hit_s       = (state_r == ST_RUN) &&
                      is_tohost_hit(mon_we, mon_addr, mon_wdata, TOHOST_ADDR);
        // A tohost hit masks the watchdog so the program's verdict wins.
        wd_enable_s = (state_r == ST_RUN) && !hit_s;
    end

    run_watchdog #(
        .CNT_W (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (start_ok_s),
        .enable  (wd_enable_s),
        .limit   (timeout_limit),
        .count   (cycle_count),
        .expired (wd_expired_s)
    );

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            addr_r       <= ADDR_ZERO;
            hold_cnt_r   <= HOLD_ZERO;
            ld_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= ADDR_ZERO;
            imem_wdata_r <= DATA_ZERO;
            core_reset_r <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            pass_r       <= 1'b0;
            fail_code_r  <= 31'd0;
            timed_out_r  <= 1'b0;
            load_ovf_r   <= 1'b0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_s) begin
                        state_r     <= ST_LOAD;
                        addr_r      <= ADDR_ZERO;
                        ld_ready_r  <= 1'b1;
                        busy_r      <= 1'b1;
                        done_r      <= 1'b0;
                        pass_r      <= 1'b0;
                        fail_code_r <= 31'd0;
                        timed_out_r <= 1'b0;
                        load_ovf_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (handshake_s) begin
                        imem_we_r    <= 1'b1;
                        imem_addr_r  <= addr_r;
                        imem_wdata_r <= ld.ld_data;
                        if (ld.ld_last) begin
                            state_r    <= ST_HOLD;
                            ld_ready_r <= 1'b0;
                            hold_cnt_r <= HOLD_ZERO;
                        end else if (addr_r == ADDR_LAST) begin
                            // Memory full before the image ended: stop here,
                            // never wrap over the words already written.
                            state_r    <= ST_HOLD;
                            ld_ready_r <= 1'b0;
                            hold_cnt_r <= HOLD_ZERO;
                            load_ovf_r <= 1'b1;
                        end else begin
                            addr_r <= addr_r + ADDR_ONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        state_r      <= ST_RUN;
                        core_reset_r <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HOLD_ONE;
                    end
                end
                ST_RUN: begin
                    if (hit_s) begin
                        state_r      <= ST_DONE;
                        core_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        pass_r       <= (mon_wdata == PASS_CODE);
                        fail_code_r  <= mon_wdata[31:1];
                    end else if (wd_expired_s) begin
                        state_r      <= ST_DONE;
                        core_reset_r <= 1'b1;
                        busy_r       <= 1'b0;
                        done_r       <= 1'b1;
                        pass_r       <= 1'b0;
                        timed_out_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    ld_ready_r   <= 1'b0;
                    core_reset_r <= 1'b1;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign ld.ld_ready   = ld_ready_r;
    assign ld.imem_we    = imem_we_r;
    assign ld.imem_addr  = imem_addr_r;
    assign ld.imem_wdata = imem_wdata_r;
    assign core_reset    = core_reset_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign pass          = pass_r;
    assign fail_code     = fail_code_r;
    assign timed_out     = timed_out_r;
    assign load_ovf      = load_ovf_r;

endmodule

// File: tb/tb_prog_run_ctrl.sv
// Bench for prog_run_ctrl: a phase-level reference model compared every
// cycle, directed scenarios with literal expectations, and a second small
// instance (ADDR_W=2) for the memory-full case.
module tb_prog_run_ctrl;
    localparam int          ADDR_W     = 10;
    localparam int          DATA_W     = 32;
    localparam int          CNT_W      = 32;
    localparam int          RESET_HOLD = 4;
    localparam int          DEPTH      = 1 << ADDR_W;
    localparam logic [31:0] TOHOST     = 32'h0000_1000;
    localparam int P_IDLE = 0, P_LOAD = 1, P_HOLD = 2, P_RUN = 3, P_DONE = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic             mon_we = 1'b0;
    logic [31:0]      mon_addr = 32'd0;
    logic [31:0]      mon_wdata = 32'd0;
    logic [CNT_W-1:0] timeout_limit = 32'd0;
    logic             core_reset, busy, done, pass, timed_out, load_ovf;
    logic [30:0]      fail_code;
    logic [CNT_W-1:0] cycle_count;

    logic             s_start = 1'b0;
    logic             s_core_reset, s_busy, s_done, s_pass, s_timed_out, s_load_ovf;
    logic [30:0]      s_fail_code;
    logic [CNT_W-1:0] s_cycle_count;

    int total = 0;
    int bad   = 0;

    prog_run_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) pif ();
    prog_run_ctrl_if #(.ADDR_W(2), .DATA_W(DATA_W)) sif ();

    prog_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W),
                    .RESET_HOLD(RESET_HOLD), .TOHOST_ADDR(TOHOST)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .ld(pif),
        .core_reset(core_reset), .mon_we(mon_we), .mon_addr(mon_addr),
        .mon_wdata(mon_wdata), .timeout_limit(timeout_limit), .busy(busy),
        .done(done), .pass(pass), .fail_code(fail_code), .timed_out(timed_out),
        .load_ovf(load_ovf), .cycle_count(cycle_count)
    );

    prog_run_ctrl #(.ADDR_W(2), .DATA_W(DATA_W), .CNT_W(CNT_W),
                    .RESET_HOLD(RESET_HOLD), .TOHOST_ADDR(TOHOST)) dut_s (
        .clk(clk), .reset_n(reset_n), .start(s_start), .ld(sif),
        .core_reset(s_core_reset), .mon_we(1'b0), .mon_addr(32'd0),
        .mon_wdata(32'd0), .timeout_limit(32'd0), .busy(s_busy),
        .done(s_done), .pass(s_pass), .fail_code(s_fail_code), .timed_out(s_timed_out),
        .load_ovf(s_load_ovf), .cycle_count(s_cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (phase level) ----------------
    int          m_phase = P_IDLE;
    int          m_addr = 0;
    int          m_hold = 0;
    longint      m_cnt = 0;
    logic        m_done = 1'b0, m_pass = 1'b0, m_to = 1'b0, m_ovf = 1'b0, m_we = 1'b0;
    logic [30:0] m_fail = 31'd0;
    int          m_waddr = 0;
    logic [31:0] m_wdata = 32'd0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_phase = P_IDLE; m_addr = 0; m_hold = 0; m_cnt = 0;
            m_done = 1'b0; m_pass = 1'b0; m_to = 1'b0; m_ovf = 1'b0;
            m_we = 1'b0; m_fail = 31'd0;
        end else begin
            m_we = 1'b0;
            case (m_phase)
                P_IDLE, P_DONE: if (start) begin
                    m_phase = P_LOAD; m_addr = 0; m_cnt = 0; m_done = 1'b0;
                    m_pass = 1'b0; m_fail = 31'd0; m_to = 1'b0; m_ovf = 1'b0;
                end
                P_LOAD: if (pif.ld_valid) begin
                    m_we = 1'b1; m_waddr = m_addr; m_wdata = pif.ld_data;
                    if (pif.ld_last) begin
                        m_phase = P_HOLD; m_hold = RESET_HOLD;
                    end else if (m_addr == DEPTH - 1) begin
                        m_phase = P_HOLD; m_hold = RESET_HOLD; m_ovf = 1'b1;
                    end else begin
                        m_addr++;
                    end
                end
                P_HOLD: begin
                    m_hold--;
                    if (m_hold == 0) m_phase = P_RUN;
                end
                P_RUN: begin
                    if (mon_we && mon_addr == TOHOST && mon_wdata != 32'd0) begin
                        m_phase = P_DONE; m_done = 1'b1;
                        m_pass = (mon_wdata == 32'd1); m_fail = mon_wdata[31:1];
                    end else if (timeout_limit != 0 && m_cnt == longint'(timeout_limit) - 1) begin
                        m_phase = P_DONE; m_done = 1'b1; m_to = 1'b1; m_pass = 1'b0;
                    end else if (m_cnt < 64'hFFFF_FFFF) begin
                        m_cnt++;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-cycle comparison of the main instance against the model.
    always @(negedge clk) begin
        chk("core_reset", core_reset, m_phase != P_RUN);
        chk("busy", busy, m_phase inside {P_LOAD, P_HOLD, P_RUN});
        chk("ld_ready", pif.ld_ready, m_phase == P_LOAD);
        chk("done", done, m_done);
        chk("pass", pass, m_pass);
        chk("fail_code", fail_code, m_fail);
        chk("timed_out", timed_out, m_to);
        chk("load_ovf", load_ovf, m_ovf);
        chk("cycle_count", cycle_count, m_cnt);
        chk("imem_we", pif.imem_we, m_we);
        if (m_we) begin
            chk("imem_addr", pif.imem_addr, m_waddr);
            chk("imem_wdata", pif.imem_wdata, m_wdata);
        end
    end

    // ---------------- observers ----------------
    int unsigned ncyc = 0;
    always @(posedge clk) ncyc <= ncyc + 1;

    int          wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int unsigned wr_cyc_q[$];
    always @(negedge clk) if (pif.imem_we) begin
        wr_addr_q.push_back(int'(pif.imem_addr));
        wr_data_q.push_back(pif.imem_wdata);
        wr_cyc_q.push_back(ncyc);
    end

    int s_wr_n = 0, s_wr_last = -1, s_acc = 0;
    always @(negedge clk) if (sif.imem_we) begin
        s_wr_n++;
        s_wr_last = int'(sif.imem_addr);
    end
    always @(posedge clk) if (sif.ld_valid && sif.ld_ready) s_acc++;

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic load_words(input int n, input logic [31:0] base);
        int g;
        for (int i = 0; i < n; i++) begin
            pif.ld_valid = 1'b1;
            pif.ld_data  = base + 32'(i);
            pif.ld_last  = (i == n - 1);
            g = 0;
            while (!pif.ld_ready && g < 20) begin
                @(negedge clk);
                g++;
            end
            chk("ld_ready_wait", pif.ld_ready, 1'b1);
            @(negedge clk);
        end
        pif.ld_valid = 1'b0;
        pif.ld_last  = 1'b0;
    endtask

    task automatic wait_run();
        int g = 0;
        while (core_reset && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("run_reached", core_reset, 1'b0);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mon_we = 1'b1; mon_addr = a; mon_wdata = d;
        @(negedge clk);
        mon_we = 1'b0; mon_addr = 32'd0; mon_wdata = 32'd0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        int n;
        pif.ld_valid = 1'b0; pif.ld_data = 32'd0; pif.ld_last = 1'b0;
        sif.ld_valid = 1'b0; sif.ld_data = 32'd0; sif.ld_last = 1'b0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_core_reset", core_reset, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ld_ready", pif.ld_ready, 1'b0);
        chk("rst_cycle_count", cycle_count, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Four-word image, release timing, then a passing verdict.
        base = wr_addr_q.size();
        pulse_start();
        load_words(4, 32'hA000_0000);
        wait_run();
        chk("a_wr_count", wr_addr_q.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            if (wr_addr_q.size() > base + i) begin
                chk("a_wr_addr", wr_addr_q[base + i], i);
                chk("a_wr_data", wr_data_q[base + i], 32'hA000_0000 + 32'(i));
            end
        end
        if (wr_cyc_q.size() >= base + 4)
            chk("a_release_gap", ncyc - wr_cyc_q[base + 3], 4);
        repeat (3) @(negedge clk);
        store(TOHOST, 32'd1);
        chk("a_done", done, 1'b1);
        chk("a_pass", pass, 1'b1);
        chk("a_fail_code", fail_code, 31'd0);
        chk("a_core_reset", core_reset, 1'b1);

        // Failing verdict; zero store and wrong-address store ignored;
        // a start during LOAD is ignored.
        pulse_start();
        pulse_start();
        load_words(3, 32'hB000_0000);
        wait_run();
        store(TOHOST, 32'd0);
        store(32'h0000_1004, 32'd1);
        chk("b_ignored_done", done, 1'b0);
        store(TOHOST, 32'd7);
        chk("b_done", done, 1'b1);
        chk("b_pass", pass, 1'b0);
        chk("b_fail_code", fail_code, 31'd3);

        // Watchdog expiry after 50 RUN cycles.
        timeout_limit = 32'd50;
        pulse_start();
        load_words(1, 32'hC000_0000);
        wait_run();
        n = 0;
        while (!done && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("c_run_cycles", n, 50);
        chk("c_timed_out", timed_out, 1'b1);
        chk("c_cycle_count", cycle_count, 32'd49);
        chk("c_pass", pass, 1'b0);
        chk("c_model_cnt", m_cnt, 49);

        // Tohost hit on the expiry cycle wins.
        pulse_start();
        load_words(1, 32'hD000_0000);
        wait_run();
        n = 0;
        while (cycle_count != 32'd49 && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk("d_reach_49", cycle_count, 32'd49);
        store(TOHOST, 32'd1);
        chk("d_done", done, 1'b1);
        chk("d_pass", pass, 1'b1);
        chk("d_timed_out", timed_out, 1'b0);
        chk("d_model_to", m_to, 1'b0);

        // Small instance: memory fills before ld_last.
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        sif.ld_valid = 1'b1;
        sif.ld_last  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            sif.ld_data = 32'd100 + 32'(s_acc);
            @(negedge clk);
        end
        sif.ld_valid = 1'b0;
        chk("e_accepted", s_acc, 4);
        chk("e_writes", s_wr_n, 4);
        chk("e_last_addr", s_wr_last, 3);
        chk("e_load_ovf", s_load_ovf, 1'b1);
        chk("e_ld_ready", sif.ld_ready, 1'b0);

        // Reset pulsed mid-RUN, then a clean restart.
        timeout_limit = 32'd0;
        pulse_start();
        load_words(3, 32'hE000_0000);
        wait_run();
        repeat (5) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("f_core_reset", core_reset, 1'b1);
        chk("f_done", done, 1'b0);
        chk("f_busy", busy, 1'b0);
        chk("f_cycle_count", cycle_count, 32'd0);
        chk("f_s_load_ovf", s_load_ovf, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start();
        load_words(2, 32'hF000_0000);
        wait_run();
        store(TOHOST, 32'd1);
        chk("f_restart_pass", pass, 1'b1);
        chk("f_restart_done", done, 1'b1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prog_run_ctrl.md
PROG_RUN_CTRL -- requirements
Module: prog_run_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADDR_W  10  instruction-memory word-address width; depth = 2**ADDR_W
  DATA_W  32  instruction word width
  CNT_W  32  cycle-counter width
  RESET_HOLD  4  cycles the core stays in reset after load, >=1
  TOHOST_ADDR  32'h0000_1000  end-of-test store address
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  single clock, rising edge
  reset_n  in  1  asynchronous, active-low reset
  start  in  1  one-cycle pulse; begins load-and-run
  ld_valid  in  1  load word valid
  ld_ready  out  1  controller accepts load word
  ld_data  in  DATA_W  load word
  ld_last  in  1  final load word
  imem_we  out  1  instruction-memory write strobe
  imem_addr  out  ADDR_W  instruction-memory word address
  imem_wdata  out  DATA_W  instruction-memory write data
  core_reset  out  1  active-high reset to the riscv core
  mon_we  in  1  core data-store strobe
  mon_addr  in  32  core store address
  mon_wdata  in  32  core store data
  timeout_limit  in  CNT_W  run-cycle budget; 0 disables the watchdog
  busy  out  1  state is LOAD, HOLD or RUN
  done  out  1  test finished; sticky
  pass  out  1  valid when done
  fail_code  out  31  mon_wdata[31:1] of the terminating store
  timed_out  out  1  watchdog expired
  load_ovf  out  1  memory filled before ld_last
  cycle_count  out  CNT_W  RUN cycles elapsed
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-004 The FSM SHALL have the states IDLE, LOAD, HOLD, RUN and DONE.
REQ-005 IDLE or DONE + start: go to LOAD; clear address, cycle_count, done, pass, fail_code, timed_out and load_ovf. start in any other state is ignored.
REQ-006 ld_ready SHALL be 1 only in LOAD; a handshake is ld_valid && ld_ready.
REQ-007 Each handshake SHALL drive imem_we=1, imem_addr=current address and imem_wdata=ld_data on the following cycle (registered, 1-cycle latency); the address then increments.
REQ-008 Handshake with ld_last: go to HOLD. Handshake at address 2**ADDR_W-1 without ld_last: set load_ovf and go to HOLD; the address SHALL NOT wrap.
REQ-009 core_reset SHALL be 1 in IDLE, LOAD, HOLD and DONE, and 0 only in RUN.
REQ-010 HOLD SHALL last exactly RESET_HOLD cycles, then go to RUN.
REQ-011 In RUN, cycle_count SHALL increment once per cycle and saturate at all-ones.
REQ-012 Tohost hit: RUN && mon_we && mon_addr==TOHOST_ADDR && mon_wdata!=0. On a hit: go to DONE; pass=(mon_wdata==1); fail_code=mon_wdata[31:1].
REQ-013 A store to TOHOST_ADDR with mon_wdata==0 SHALL be ignored.
REQ-014 When timeout_limit!=0 and cycle_count==timeout_limit-1 in RUN: go to DONE with timed_out=1 and pass=0.
REQ-015 A tohost hit and a timeout in the same cycle: the tohost hit wins and timed_out stays 0.
REQ-016 DONE: done=1 and all results hold until the next start.

Reset
REQ-017 While reset_n=0, the block SHALL be in IDLE with core_reset=1, every other output 0 and all counters 0, regardless of state (including mid-LOAD or mid-RUN).
REQ-018 reset_n deassertion SHALL take effect on the next rising clk edge; no output glitches during a reset in progress.

Structure
REQ-019 Package prog_run_pkg SHALL hold the state enum, the default TOHOST_ADDR and the PASS_CODE=1 constant.
REQ-020 The cycle counter and timeout compare SHALL be a sub-module, run_watchdog (ports: clk, reset_n, clear, enable, limit, count, expired).

Verification
REQ-021 Load 4 words (last on the 4th), RESET_HOLD=4 -> imem writes to addresses 0..3, each one cycle after its handshake; core_reset falls exactly 4 cycles after the last write.
REQ-022 In RUN, store 1 to 0x1000 -> done=1, pass=1, fail_code=0, core_reset=1.
REQ-023 In RUN, store 7 to 0x1000 -> pass=0, fail_code=3; a prior store of 0 to 0x1000 and a store of 1 to 0x1004 are both ignored.
REQ-024 timeout_limit=50, no store -> done after 50 RUN cycles with timed_out=1 and cycle_count=49; a tohost store of 1 on that same cycle -> pass=1, timed_out=0.
REQ-025 ADDR_W=2, 5 words with no ld_last -> 4 writes, load_ovf=1, and the 5th word is not accepted.
REQ-026 reset_n pulsed low mid-RUN -> immediately IDLE, core_reset=1, done=0; start then restarts cleanly.
